// File: rtl/jtag_pkg.sv
// Shared constants and types for the JTAG data-register controller.
package jtag_pkg;

  localparam int IR_WIDTH = 4;

  localparam logic [IR_WIDTH-1:0] LOAD_PROGRAM = 4'b0001;
  localparam logic [IR_WIDTH-1:0] SCAN_TEST    = 4'b0010;
  localparam logic [IR_WIDTH-1:0] BYPASS       = 4'b0011;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE   = 4'b0101;

  // SCAN_TEST status word layout: {overrun, busy, zeros, word count}.
  localparam int STATUS_WIDTH       = 32;
  localparam int STATUS_OVERRUN_BIT = 31;
  localparam int STATUS_BUSY_BIT    = 30;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } wr_state_t;

endpackage

// File: rtl/jtag_shift_reg.sv
// Generic JTAG shift register: parallel capture, LSB-first right shift, hold.
module jtag_shift_reg #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             tck_i,
  input  logic             trst_i,
  input  logic             captureEn_i,
  input  logic [WIDTH-1:0] captureVal_i,
  input  logic             shiftEn_i,
  input  logic             serial_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] qReg;
  logic [WIDTH-1:0] shiftNext;

  // Each bit takes its upper neighbour; the serial input enters at the MSB.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : gShift
      assign shiftNext[gi] = qReg[gi + 1];
    end
  endgenerate
  assign shiftNext[WIDTH-1] = serial_i;

  // Capture has priority over shift; otherwise the contents are held.
  always_ff @(posedge tck_i or negedge trst_i) begin
    if (!trst_i) begin
      qReg <= RESET_VALUE;
    end else if (captureEn_i) begin
      qReg <= captureVal_i;
    end else if (shiftEn_i) begin
      qReg <= shiftNext;
    end
  end

  assign q_o = qReg;

endmodule

// File: rtl/jtag_dr_controller.sv
// JTAG IR/DR controller: instruction decode, TDO mux and program-memory
// write handshake for the LOAD_PROGRAM data register.
module jtag_dr_controller
  import jtag_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16   // at most 16: lives in status bits [15:0]
) (
  input  logic                  tck_i,
  input  logic                  trst_i,
  input  logic                  tdi_i,
  input  logic                  shiftIR_i,
  input  logic                  updateIR_i,
  input  logic                  shiftDR_i,
  input  logic                  updateDR_i,
  input  logic                  SelectIR_i,
  output logic                  tdo_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  output logic                  prog_mode_o
);

  localparam int DR_WIDTH = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [IR_WIDTH-1:0]     irReg;
  logic [IR_WIDTH-1:0]     irNext;
  logic [IR_WIDTH-1:0]     irSr;
  logic                    bypassReg;
  logic [DR_WIDTH-1:0]     drSr;
  logic [STATUS_WIDTH-1:0] statusSr;
  logic [STATUS_WIDTH-1:0] statusLive;
  wr_state_t               stateReg;
  wr_state_t               stateNext;
  logic [CNT_WIDTH-1:0]    wordCntReg;
  logic                    overrunReg;
  logic                    progModeReg;
  logic [ADDR_WIDTH-1:0]   memAddrReg;
  logic [DATA_WIDTH-1:0]   memWdataReg;

  logic irIsLoad;
  logic irIsScan;
  logic irLoadWrite;
  logic drUpdateLoad;

  assign irIsLoad     = (irReg == LOAD_PROGRAM);
  assign irIsScan     = (irReg == SCAN_TEST);
  assign irLoadWrite  = updateIR_i && (irSr == LOAD_PROGRAM);
  assign drUpdateLoad = updateDR_i && irIsLoad;

  // IR shift register: captures 0101 whenever the TAP is not shifting IR.
  jtag_shift_reg #(
    .WIDTH       (IR_WIDTH),
    .RESET_VALUE (IR_CAPTURE)
  ) uIrSr (
    .tck_i        (tck_i),
    .trst_i       (trst_i),
    .captureEn_i  (!shiftIR_i),
    .captureVal_i (IR_CAPTURE),
    .shiftEn_i    (shiftIR_i),
    .serial_i     (tdi_i),
    .q_o          (irSr)
  );

  // Program data register {addr, data}: never captures, only shifts or holds.
  jtag_shift_reg #(
    .WIDTH       (DR_WIDTH),
    .RESET_VALUE ('0)
  ) uDrSr (
    .tck_i        (tck_i),
    .trst_i       (trst_i),
    .captureEn_i  (1'b0),
    .captureVal_i ({DR_WIDTH{1'b0}}),
    .shiftEn_i    (shiftDR_i && irIsLoad),
    .serial_i     (tdi_i),
    .q_o          (drSr)
  );

  // Status register: snapshots the live status whenever DR is not shifting.
  jtag_shift_reg #(
    .WIDTH       (STATUS_WIDTH),
    .RESET_VALUE ('0)
  ) uStatusSr (
    .tck_i        (tck_i),
    .trst_i       (trst_i),
    .captureEn_i  (!shiftDR_i),
    .captureVal_i (statusLive),
    .shiftEn_i    (shiftDR_i && irIsScan),
    .serial_i     (tdi_i),
    .q_o          (statusSr)
  );

  // Assemble the live status word from the write-path state.
  always_comb begin
    statusLive                     = '0;
    statusLive[STATUS_OVERRUN_BIT] = overrunReg;
    statusLive[STATUS_BUSY_BIT]    = (stateReg == REQ);
    statusLive[CNT_WIDTH-1:0]      = wordCntReg;
  end

  // Instruction register update from the IR shift register.
  always_ff @(posedge tck_i or negedge trst_i) begin
    if (!trst_i) begin
      irReg <= BYPASS;
    end else if (updateIR_i) begin
      irReg <= irSr;
    end
  end

  // One-bit bypass register, zeroed outside SHIFT_DR.
  always_ff @(posedge tck_i or negedge trst_i) begin
    if (!trst_i) begin
      bypassReg <= 1'b0;
    end else begin
      bypassReg <= shiftDR_i ? tdi_i : 1'b0;
    end
  end

  // Write FSM state register.
  always_ff @(posedge tck_i or negedge trst_i) begin
    if (!trst_i) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Write FSM next state and the instruction value the next edge will hold.
  always_comb begin
    stateNext = stateReg;
    irNext    = updateIR_i ? irSr : irReg;
    unique case (stateReg)
      IDLE:    if (drUpdateLoad) stateNext = REQ;
      REQ:     if (mem_ack_i)    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Latch address/data only when a request starts; an update during REQ is dropped.
  always_ff @(posedge tck_i or negedge trst_i) begin
    if (!trst_i) begin
      memAddrReg  <= '0;
      memWdataReg <= '0;
    end else if ((stateReg == IDLE) && drUpdateLoad) begin
      memAddrReg  <= drSr[DR_WIDTH-1:DATA_WIDTH];
      memWdataReg <= drSr[DATA_WIDTH-1:0];
    end
  end

  // Accepted-write counter and sticky overrun flag; a LOAD_PROGRAM IR write clears both.
  always_ff @(posedge tck_i or negedge trst_i) begin
    if (!trst_i) begin
      wordCntReg <= '0;
      overrunReg <= 1'b0;
    end else if (irLoadWrite) begin
      wordCntReg <= '0;
      overrunReg <= 1'b0;
    end else begin
      if ((stateReg == REQ) && mem_ack_i) begin
        wordCntReg <= wordCntReg + CNT_ONE;
      end
      if ((stateReg == REQ) && drUpdateLoad) begin
        overrunReg <= 1'b1;
      end
    end
  end

  // Program mode tracks the post-edge instruction and FSM state, so a pending
  // request keeps the core held even after the IR moves away.
  always_ff @(posedge tck_i or negedge trst_i) begin
    if (!trst_i) begin
      progModeReg <= 1'b0;
    end else begin
      progModeReg <= (irNext == LOAD_PROGRAM) || (stateNext == REQ);
    end
  end

  // TDO source selection.
  always_comb begin
    tdo_o = bypassReg;
    if (SelectIR_i) begin
      tdo_o = irSr[0];
    end else if (irIsLoad) begin
      tdo_o = drSr[0];
    end else if (irIsScan) begin
      tdo_o = statusSr[0];
    end
  end

  assign mem_req_o   = (stateReg == REQ);
  assign mem_addr_o  = memAddrReg;
  assign mem_wdata_o = memWdataReg;
  assign prog_mode_o = progModeReg;

endmodule

// File: tb/tb_jtag_dr_controller.sv
// Directed self-checking bench for jtag_dr_controller.
module tb_jtag_dr_controller;

  logic        tck = 1'b0;
  logic        trst;
  logic        tdi;
  logic        shiftIR;
  logic        updateIR;
  logic        shiftDR;
  logic        updateDR;
  logic        selectIR;
  logic        tdo;
  logic        memReq;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic        memAck;
  logic        progMode;

  int checks = 0;
  int errors = 0;

  always #5 tck = ~tck;

  jtag_dr_controller #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .CNT_WIDTH  (16)
  ) dut (
    .tck_i       (tck),
    .trst_i      (trst),
    .tdi_i       (tdi),
    .shiftIR_i   (shiftIR),
    .updateIR_i  (updateIR),
    .shiftDR_i   (shiftDR),
    .updateDR_i  (updateDR),
    .SelectIR_i  (selectIR),
    .tdo_o       (tdo),
    .mem_req_o   (memReq),
    .mem_addr_o  (memAddr),
    .mem_wdata_o (memWdata),
    .mem_ack_i   (memAck),
    .prog_mode_o (progMode)
  );

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      $display("check %s observed=%h expected=%h ok", tag, observed, expected);
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Shift a 4-bit instruction LSB first, collecting TDO, then pulse UPDATE_IR.
  task automatic shiftIr(input logic [3:0] val, output logic [3:0] outBits);
    selectIR = 1'b1;
    shiftIR  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tdi = val[i];
      #1;
      outBits[i] = tdo;
      @(negedge tck);
    end
    shiftIR  = 1'b0;
    updateIR = 1'b1;
    @(negedge tck);
    updateIR = 1'b0;
  endtask

  // Shift n DR bits LSB first, collecting TDO.
  task automatic shiftDr(input int n, input logic [63:0] val, output logic [63:0] outBits);
    outBits  = '0;
    selectIR = 1'b0;
    shiftDR  = 1'b1;
    for (int i = 0; i < n; i++) begin
      tdi = val[i];
      #1;
      outBits[i] = tdo;
      @(negedge tck);
    end
    shiftDR = 1'b0;
  endtask

  task automatic updateDr();
    updateDR = 1'b1;
    @(negedge tck);
    updateDR = 1'b0;
  endtask

  logic [3:0]  irOut;
  logic [63:0] drOut;
  int          highCycles;

  initial begin
    trst = 1'b0; tdi = 1'b0; shiftIR = 1'b0; updateIR = 1'b0;
    shiftDR = 1'b0; updateDR = 1'b0; selectIR = 1'b0; memAck = 1'b0;

    // Reset state
    repeat (2) @(negedge tck);
    chk("rst_req", 64'(memReq), 64'd0);
    chk("rst_prog", 64'(progMode), 64'd0);
    chk("rst_addr", 64'(memAddr), 64'd0);
    chk("rst_ir", 64'(dut.irReg), 64'h3);
    trst = 1'b1;
    @(negedge tck);

    // IR capture pattern, BYPASS re-written
    shiftIr(4'b0011, irOut);
    chk("ir_capture", 64'(irOut), 64'h5);
    chk("ir_bypass", 64'(dut.irReg), 64'h3);
    chk("bypass_prog", 64'(progMode), 64'd0);

    // Bypass path: in 1,0,1,1 -> out 0,1,0,1
    shiftDr(4, 64'b1101, drOut);
    chk("bypass_tdo", drOut, 64'b1010);

    // Unknown instruction behaves as bypass
    shiftIr(4'b1111, irOut);
    shiftDr(2, 64'b11, drOut);
    chk("unknown_bypass", drOut, 64'b10);

    // Single program write, ack on the third REQ cycle
    shiftIr(4'b0001, irOut);
    chk("load_prog", 64'(progMode), 64'd1);
    shiftDr(64, {32'h0000_0010, 32'hDEAD_BEEF}, drOut);
    updateDr();
    chk("w1_addr", 64'(memAddr), 64'h10);
    chk("w1_data", 64'(memWdata), 64'hDEAD_BEEF);
    chk("w1_prog", 64'(progMode), 64'd1);
    highCycles = 0;
    repeat (3) begin
      if (memReq) highCycles++;
      if (highCycles == 3) memAck = 1'b1;
      @(negedge tck);
    end
    memAck = 1'b0;
    chk("w1_req_cycles", 64'(highCycles), 64'd3);
    chk("w1_req_done", 64'(memReq), 64'd0);

    // Ack in IDLE is ignored
    memAck = 1'b1;
    @(negedge tck);
    memAck = 1'b0;
    chk("idle_ack_req", 64'(memReq), 64'd0);

    // Count after one write
    shiftIr(4'b0010, irOut);
    chk("scan_prog", 64'(progMode), 64'd0);
    shiftDr(32, 64'd0, drOut);
    chk("status_one", drOut, 64'h0000_0001);

    // Overrun: second update while the first request is outstanding
    shiftIr(4'b0001, irOut);
    shiftDr(64, {32'h0000_0020, 32'h1234_5678}, drOut);
    updateDr();
    chk("w2_req", 64'(memReq), 64'd1);
    shiftDr(64, {32'h0000_0030, 32'hCAFE_F00D}, drOut);
    updateDr();
    chk("ovr_req", 64'(memReq), 64'd1);
    chk("ovr_addr", 64'(memAddr), 64'h20);
    chk("ovr_data", 64'(memWdata), 64'h1234_5678);
    shiftIr(4'b0010, irOut);
    chk("ovr_prog_held", 64'(progMode), 64'd1);
    shiftDr(32, 64'd0, drOut);
    chk("status_ovr", drOut, 64'hC000_0000);
    memAck = 1'b1;
    @(negedge tck);
    memAck = 1'b0;
    chk("ovr_ack_req", 64'(memReq), 64'd0);
    chk("ovr_ack_prog", 64'(progMode), 64'd0);

    // Five acked writes, then status readout
    shiftIr(4'b0001, irOut);
    for (int k = 1; k <= 5; k++) begin
      shiftDr(64, {32'(k * 4), 32'(k)}, drOut);
      updateDr();
      chk($sformatf("w5_addr%0d", k), 64'(memAddr), 64'(k * 4));
      memAck = 1'b1;
      @(negedge tck);
      memAck = 1'b0;
    end
    shiftIr(4'b0010, irOut);
    shiftDr(32, 64'd0, drOut);
    chk("status_five", drOut, 64'h0000_0005);

    // Reset mid-request, no clock edge
    shiftIr(4'b0001, irOut);
    shiftDr(64, {32'h0000_0040, 32'h0BAD_CAFE}, drOut);
    updateDr();
    chk("rr_req", 64'(memReq), 64'd1);
    trst = 1'b0;
    #1;
    chk("rr_req_drop", 64'(memReq), 64'd0);
    chk("rr_prog", 64'(progMode), 64'd0);
    chk("rr_ir", 64'(dut.irReg), 64'h3);
    chk("rr_addr", 64'(memAddr), 64'd0);
    @(negedge tck);
    trst = 1'b1;
    @(negedge tck);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
